// File: rtl/apu_irq_ctrl_if.sv
// AHB-Lite bus bundle for the APU interrupt aggregator's register port.
// The master modport is the bus side (CPU/interconnect) and the slave
// modport is the register block.
interface apu_irq_ctrl_if;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr,
        output htrans,
        output hwrite,
        output hsize,
        output hready,
        output hwdata,
        input  hready_resp,
        input  hresp,
        input  hrdata
    );

    modport slave (
        input  haddr,
        input  htrans,
        input  hwrite,
        input  hsize,
        input  hready,
        input  hwdata,
        output hready_resp,
        output hresp,
        output hrdata
    );
endinterface

// File: rtl/apu_irq_ctrl.sv
// APU interrupt aggregator: latches level and edge requests, masks them
// with ENABLE, merges in software-forced requests and presents a single
// registered interrupt plus the lowest-numbered active source to the CPU.
// Configured through a zero-wait-state AHB-Lite slave port.
module apu_irq_ctrl #(
    parameter int                N_IRQ    = 8,
    parameter logic [N_IRQ-1:0]  IRQ_EDGE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    apu_irq_ctrl_if.slave    ahbls,
    input  logic [N_IRQ-1:0] irq_src,
    output logic             irq,
    output logic [4:0]       irq_num
);

    // Register map, selected by word address bits [4:2]
    typedef enum logic [2:0] {
        REG_ENABLE  = 3'd0,
        REG_PENDING = 3'd1,
        REG_FORCE   = 3'd2,
        REG_NEXT    = 3'd3,
        REG_RAW     = 3'd4
    } reg_sel_e;

    // Data-phase bookkeeping captured from the address phase
    logic       dphase_q;
    logic       dwrite_q;
    reg_sel_e   dsel_q;

    // Architectural state
    logic [N_IRQ-1:0] enable_q;
    logic [N_IRQ-1:0] force_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] src_q;

    // Derived combinational signals
    logic             wr_strobe;
    logic [N_IRQ-1:0] wdata;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] w1c_mask;
    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] active;
    logic             next_valid;
    logic [4:0]       next_idx;
    logic             unused_bus;

    // The slave never stalls and never errors, even while in reset
    assign ahbls.hready_resp = 1'b1;
    assign ahbls.hresp       = 1'b0;

    // Transfer size and the undecoded address/data bits carry no meaning here
    assign unused_bus = ^{ahbls.hsize, ahbls.haddr[15:5], ahbls.haddr[1:0],
                          ahbls.htrans[0], ahbls.hwdata};

    // Capture the address phase so the following data phase knows its target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            dsel_q   <= REG_ENABLE;
        end else if (ahbls.hready) begin
            dphase_q <= ahbls.htrans[1];
            if (ahbls.htrans[1]) begin
                dwrite_q <= ahbls.hwrite;
                dsel_q   <= reg_sel_e'(ahbls.haddr[4:2]);
            end
        end
    end

    // A write lands on the edge that ends its data phase
    assign wr_strobe = dphase_q & dwrite_q & ahbls.hready;
    assign wdata     = ahbls.hwdata[N_IRQ-1:0];

    // Sample the request inputs; RAW reads and edge detection both use this
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else begin
            src_q <= irq_src;
        end
    end

    // Software-owned mask and force registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            force_q  <= '0;
        end else if (wr_strobe) begin
            if (dsel_q == REG_ENABLE) begin
                enable_q <= wdata;
            end
            if (dsel_q == REG_FORCE) begin
                force_q <= wdata;
            end
        end
    end

    // Level bits follow the input; edge bits set on a rising edge (winning
    // over a simultaneous clear) and are cleared by writing 1 to PENDING
    always_comb begin
        w1c_mask    = '0;
        edge_set    = irq_src & ~src_q;
        if (wr_strobe && (dsel_q == REG_PENDING)) begin
            w1c_mask = wdata;
        end
        pending_nxt = (IRQ_EDGE & (edge_set | (pending_q & ~w1c_mask)))
                    | (~IRQ_EDGE & irq_src);
    end

    // Pending request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    // Lowest-numbered active source wins
    always_comb begin
        active     = (pending_q | force_q) & enable_q;
        next_valid = |active;
        next_idx   = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                next_idx = 5'(i);
            end
        end
    end

    // Registered interrupt outputs so the CPU sees a glitch-free line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq     <= 1'b0;
            irq_num <= 5'd0;
        end else begin
            irq     <= next_valid;
            irq_num <= next_idx;
        end
    end

    // Read data reflects current register state during a read data phase
    always_comb begin
        ahbls.hrdata = 32'd0;
        if (dphase_q && !dwrite_q) begin
            case (dsel_q)
                REG_ENABLE:  ahbls.hrdata = 32'(enable_q);
                REG_PENDING: ahbls.hrdata = 32'(pending_q);
                REG_FORCE:   ahbls.hrdata = 32'(force_q);
                REG_NEXT:    ahbls.hrdata = {next_valid, 26'd0, next_idx};
                REG_RAW:     ahbls.hrdata = 32'(src_q);
                default:     ahbls.hrdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_apu_irq_ctrl.sv
// Testbench for apu_irq_ctrl: directed scenarios followed by randomized bus
// traffic and request activity, compared against a cycle-level reference model.
module tb_apu_irq_ctrl;

    localparam int         N    = 8;
    localparam logic [7:0] EDGE = 8'hC8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_src = 8'h00;
    logic       irq;
    logic [4:0] irq_num;

    apu_irq_ctrl_if bus();

    apu_irq_ctrl #(.N_IRQ(N), .IRQ_EDGE(EDGE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ahbls   (bus),
        .irq_src (irq_src),
        .irq     (irq),
        .irq_num (irq_num)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  m_enable, m_force, m_pending, m_src_q;
    logic        m_irq;
    logic [4:0]  m_num;
    bit          dp_valid, dp_write;
    logic [15:0] dp_addr;
    bit          model_on = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 5'(i);
        end
        return 5'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [7:0] act;
        act = (m_pending | m_force) & m_enable;
        case (a[4:2])
            3'd0: return {24'd0, m_enable};
            3'd1: return {24'd0, m_pending};
            3'd2: return {24'd0, m_force};
            3'd3: return (act != 0) ? {1'b1, 26'd0, lowest(act)} : 32'd0;
            3'd4: return {24'd0, m_src_q};
            default: return 32'd0;
        endcase
    endfunction

    task automatic reset_model();
        m_enable = 0; m_force = 0; m_pending = 0; m_src_q = 0;
        m_irq = 0; m_num = 0;
        dp_valid = 0; dp_write = 0; dp_addr = 0;
    endtask

    // One clock: predict the edge from the rules, then compare outputs
    task automatic tick();
        logic [7:0] act, nxt;
        bit         commit;
        logic [2:0] sel;
        act    = (m_pending | m_force) & m_enable;
        commit = dp_valid && dp_write;
        sel    = dp_addr[4:2];
        for (int i = 0; i < 8; i++) begin
            if (EDGE[i]) begin
                if (irq_src[i] && !m_src_q[i])                    nxt[i] = 1'b1;
                else if (commit && sel == 3'd1 && bus.hwdata[i])  nxt[i] = 1'b0;
                else                                              nxt[i] = m_pending[i];
            end else begin
                nxt[i] = irq_src[i];
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else begin
            m_irq     = |act;
            m_num     = lowest(act);
            m_pending = nxt;
            m_src_q   = irq_src;
            if (commit && sel == 3'd0) m_enable = bus.hwdata[7:0];
            if (commit && sel == 3'd2) m_force  = bus.hwdata[7:0];
            dp_valid = bus.hready && bus.htrans[1];
            if (dp_valid) begin
                dp_write = bus.hwrite;
                dp_addr  = bus.haddr;
            end
        end
        #1;
        if (model_on) begin
            check("irq", {31'd0, irq}, {31'd0, m_irq});
            check("irq_num", {27'd0, irq_num}, {27'd0, m_num});
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        bus.haddr = a; bus.htrans = 2'b10; bus.hwrite = 1'b1;
        tick();
        bus.htrans = 2'b00; bus.hwdata = d;
        tick();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        bus.haddr = a; bus.htrans = 2'b10; bus.hwrite = 1'b0;
        tick();
        bus.htrans = 2'b00;
        d = bus.hrdata;
        check($sformatf("rd@%h", a), d, model_read(a));
    endtask

    // Write immediately followed by a read whose address phase overlaps it
    task automatic bus_write_read(input logic [15:0] a, input logic [31:0] d);
        bus.haddr = a; bus.htrans = 2'b10; bus.hwrite = 1'b1;
        tick();
        bus.hwdata = d; bus.hwrite = 1'b0;
        tick();
        bus.htrans = 2'b00;
        check($sformatf("wr_rd@%h", a), bus.hrdata, model_read(a));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, then randomized traffic
    initial begin
        logic [31:0] rd;
        logic [15:0] a;
        int          op;

        bus.haddr = 0; bus.htrans = 0; bus.hwrite = 0; bus.hsize = 3'b010;
        bus.hready = 1'b1; bus.hwdata = 0;
        reset_model();
        #2;
        check("hready_resp_in_reset", {31'd0, bus.hready_resp}, 32'd1);
        check("hresp_in_reset", {31'd0, bus.hresp}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        model_on = 1;
        tick();
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_irq_num", {27'd0, irq_num}, 32'd0);
        check("hrdata_idle", bus.hrdata, 32'd0);
        foreach (a[i]) begin end
        for (int k = 0; k < 5; k++) begin
            bus_read(16'(k * 4), rd);
            check($sformatf("reset_rd%0d", k), rd, 32'd0);
        end
        check("hready_resp", {31'd0, bus.hready_resp}, 32'd1);
        check("hresp", {31'd0, bus.hresp}, 32'd0);

        // Level source 0
        bus_write(16'h0000, 32'h01);
        tick();
        irq_src = 8'h01;
        tick();
        check("lvl_irq_n1", {31'd0, irq}, 32'd0);
        tick();
        check("lvl_irq_n2", {31'd0, irq}, 32'd1);
        check("lvl_num", {27'd0, irq_num}, 32'd0);
        repeat (5) tick();
        irq_src = 8'h00;
        tick();
        check("lvl_off_n1", {31'd0, irq}, 32'd1);
        tick();
        check("lvl_off_n2", {31'd0, irq}, 32'd0);

        // Edge source 3
        bus_write(16'h0000, 32'h08);
        irq_src = 8'h08; tick();
        irq_src = 8'h00; tick();
        bus_read(16'h0004, rd);
        check("edge_pend", rd, 32'h08);
        check("edge_num", {27'd0, irq_num}, 32'd3);
        irq_src = 8'h08; tick(); tick();
        bus_write(16'h0004, 32'h08);
        bus_read(16'h0004, rd);
        check("edge_held_w1c", rd, 32'h00);
        irq_src = 8'h00; tick();
        irq_src = 8'h08; tick();
        irq_src = 8'h00;
        bus_read(16'h0004, rd);
        check("edge_repulse", rd, 32'h08);

        // W1C colliding with a new rising edge
        bus.haddr = 16'h0004; bus.htrans = 2'b10; bus.hwrite = 1'b1;
        tick();
        bus.htrans = 2'b00; bus.hwdata = 32'h08; irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        bus_read(16'h0004, rd);
        check("set_beats_w1c", rd, 32'h08);

        // Priority
        bus_write(16'h0004, 32'hFF);
        irq_src = 8'h04; tick();
        irq_src = 8'h0C; tick();
        irq_src = 8'h04; tick();
        bus_write(16'h0000, 32'hFF);
        bus_read(16'h000C, rd);
        check("prio_next2", rd, 32'h80000002);
        bus_write(16'h0000, 32'hF8);
        bus_read(16'h000C, rd);
        check("prio_next3", rd, 32'h80000003);
        check("prio_num3", {27'd0, irq_num}, 32'd3);

        // Force
        irq_src = 8'h00;
        bus_write(16'h0004, 32'hFF);
        bus_write(16'h0000, 32'h80);
        bus_write(16'h0008, 32'h80);
        tick(); tick();
        check("force_irq", {31'd0, irq}, 32'd1);
        check("force_num", {27'd0, irq_num}, 32'd7);
        bus_write(16'h0000, 32'h00);
        bus_read(16'h000C, rd);
        check("force_masked_next", rd, 32'd0);
        check("force_masked_irq", {31'd0, irq}, 32'd0);
        bus_write(16'h001C, 32'hFFFF_FFFF);
        bus_read(16'h001C, rd);
        check("unmapped_rd", rd, 32'd0);
        bus_read(16'h0008, rd);
        check("force_rd", rd, 32'h80);
        bus_write(16'h0008, 32'h00);

        // Upper bits ignored, back-to-back write then read
        bus_write_read(16'h0000, 32'hFFFF_FF55);
        bus_read(16'h0000, rd);
        check("enable_width", rd, 32'h55);

        // Reset in the middle of a write abandons it
        bus.haddr = 16'h0000; bus.htrans = 2'b10; bus.hwrite = 1'b1;
        tick();
        bus.htrans = 2'b00; bus.hwdata = 32'hAA;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(16'h0000, rd);
        check("reset_abandon", rd, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            irq_src = 8'($urandom);
            op      = $urandom_range(0, 3);
            a       = {11'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
            case (op)
                0: bus_write(a, $urandom);
                1: bus_read(a, rd);
                2: bus_write_read(a, $urandom);
                default: begin
                    tick();
                    check("hrdata_idle_rnd", bus.hrdata, 32'd0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
